// File: rtl/axi_to_mem_pkg.sv
// axi_to_mem_pkg: shared scheduler state encoding and default response-metadata record
package axi_to_mem_pkg;
  typedef enum logic [1:0] {IDLE, LOCK_RD, LOCK_WR} sched_state_e;
  localparam int unsigned DefIdWidth = 4;
  typedef struct packed {
    logic                  we;
    logic [DefIdWidth-1:0] id;
    logic                  last;
  } rsp_meta_t;
endpackage

// File: rtl/axi_to_mem_meta_fifo.sv
// axi_to_mem_meta_fifo: in-order FIFO of response metadata with push/pop/full/empty/head
module axi_to_mem_meta_fifo
  import axi_to_mem_pkg::*;
#(
  parameter int unsigned Depth  = 2,
  parameter type         meta_t = rsp_meta_t
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  push_i,
  input  meta_t data_i,
  input  logic  pop_i,
  output logic  full_o,
  output logic  empty_o,
  output meta_t head_o
);
  localparam int unsigned PtrW = Depth > 1 ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);
  meta_t           mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            push_ok, pop_ok;
  // occupancy flags, head view and pointer/count updates; a pop while empty is ignored
  always_comb begin
    full_o  = cnt_q == CntW'(Depth);
    empty_o = cnt_q == '0;
    head_o  = empty_o ? '0 : mem_q[rptr_q];
    push_ok = push_i && !full_o;
    pop_ok  = pop_i && !empty_o;
    wptr_d  = !push_ok ? wptr_q : wptr_q == PtrW'(Depth - 1) ? '0 : wptr_q + 1'b1;
    rptr_d  = !pop_ok ? rptr_q : rptr_q == PtrW'(Depth - 1) ? '0 : rptr_q + 1'b1;
    cnt_d   = cnt_q + CntW'(push_ok) - CntW'(pop_ok);
  end
  // pointer and count registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end
  // storage needs no reset: entries are only visible once counted
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end
  // a memory response with nothing outstanding is a protocol violation
  assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o));
endmodule

// File: rtl/axi_to_mem_rw_sched.sv
// axi_to_mem_rw_sched: burst-locked round-robin read/write beat scheduler (AXI_TO_MEM_RW_SCHED_WR_PRIO_EN: write always wins in IDLE)
module axi_to_mem_rw_sched
  import axi_to_mem_pkg::*;
#(
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   rd_valid_i,
  output logic                   rd_ready_o,
  input  logic [AddrWidth-1:0]   rd_addr_i,
  input  logic [IdWidth-1:0]     rd_id_i,
  input  logic                   rd_last_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [AddrWidth-1:0]   wr_addr_i,
  input  logic [IdWidth-1:0]     wr_id_i,
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic [DataWidth/8-1:0] wr_strb_i,
  input  logic                   wr_last_i,
  output logic                   mem_req_o,
  input  logic                   mem_gnt_i,
  output logic [AddrWidth-1:0]   mem_addr_o,
  output logic                   mem_we_o,
  output logic [DataWidth-1:0]   mem_wdata_o,
  output logic [DataWidth/8-1:0] mem_strb_o,
  input  logic                   mem_rvalid_i,
  output logic                   rsp_valid_o,
  output logic                   rsp_we_o,
  output logic [IdWidth-1:0]     rsp_id_o,
  output logic                   rsp_last_o,
  output logic                   busy_o
);
  typedef struct packed {
    logic               we;
    logic [IdWidth-1:0] id;
    logic               last;
  } meta_t;
  sched_state_e       state_q, state_d;
  logic               prio_q, prio_d;
  logic               wr_wins, sel_wr, sel_valid, sel_last, hs, full, empty;
  logic [IdWidth-1:0] sel_id;
  meta_t              push_meta, head;
`ifdef AXI_TO_MEM_RW_SCHED_WR_PRIO_EN
  assign wr_wins = 1'b1;
`else
  assign wr_wins = prio_q;
`endif
  // side selection, memory port drive, handshake and next lock/priority
  always_comb begin
    sel_wr      = state_q == LOCK_WR || (state_q == IDLE && wr_valid_i && (!rd_valid_i || wr_wins));
    sel_valid   = sel_wr ? wr_valid_i : rd_valid_i;
    sel_last    = sel_wr ? wr_last_i : rd_last_i;
    sel_id      = sel_wr ? wr_id_i : rd_id_i;
    mem_req_o   = sel_valid && !full;
    hs          = mem_req_o && mem_gnt_i;
    rd_ready_o  = hs && !sel_wr;
    wr_ready_o  = hs && sel_wr;
    mem_we_o    = sel_valid && sel_wr;
    mem_addr_o  = !sel_valid ? '0 : sel_wr ? wr_addr_i : rd_addr_i;
    mem_wdata_o = mem_we_o ? wr_data_i : '0;
    mem_strb_o  = mem_we_o ? wr_strb_i : '0;
    state_d     = !hs ? state_q : sel_last ? IDLE : sel_wr ? LOCK_WR : LOCK_RD;
    prio_d      = hs && sel_last ? !sel_wr : prio_q;
    push_meta   = '{we: sel_wr, id: sel_id, last: sel_last};
    rsp_valid_o = mem_rvalid_i;
    rsp_we_o    = head.we;
    rsp_id_o    = head.id;
    rsp_last_o  = head.last;
    busy_o      = state_q != IDLE || !empty;
  end
  // lock state and round-robin pointer (0 = read)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
    end
  end
  axi_to_mem_meta_fifo #(.Depth(MaxOutstanding), .meta_t(meta_t)) u_meta_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (hs),
    .data_i (push_meta),
    .pop_i  (mem_rvalid_i),
    .full_o (full),
    .empty_o(empty),
    .head_o (head)
  );
endmodule

// File: tb/tb_axi_to_mem_rw_sched.sv
// tb_axi_to_mem_rw_sched: table-driven cycle vectors plus hand-written reset and write-priority sequences
module tb_axi_to_mem_rw_sched;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        rd_valid_i = 1'b0, rd_ready_o, rd_last_i = 1'b0;
  logic [31:0] rd_addr_i = '0;
  logic [3:0]  rd_id_i = '0;
  logic        wr_valid_i = 1'b0, wr_ready_o, wr_last_i = 1'b0;
  logic [31:0] wr_addr_i = '0;
  logic [3:0]  wr_id_i = '0;
  logic [63:0] wr_data_i = '0;
  logic [7:0]  wr_strb_i = 8'hFF;
  logic        mem_req_o, mem_gnt_i = 1'b0, mem_we_o, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o;
  logic [63:0] mem_wdata_o;
  logic [7:0]  mem_strb_o;
  logic        rsp_valid_o, rsp_we_o, rsp_last_o, busy_o;
  logic [3:0]  rsp_id_o;
  int          n_chk = 0, n_fail = 0;

  axi_to_mem_rw_sched dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_addr_i(rd_addr_i),
    .rd_id_i(rd_id_i), .rd_last_i(rd_last_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_addr_i(wr_addr_i),
    .wr_id_i(wr_id_i), .wr_data_i(wr_data_i), .wr_strb_i(wr_strb_i), .wr_last_i(wr_last_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_strb_o(mem_strb_o), .mem_rvalid_i(mem_rvalid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_we_o(rsp_we_o), .rsp_id_o(rsp_id_o),
    .rsp_last_o(rsp_last_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic rv; logic [31:0] ra; logic [3:0] rid; logic rl;
    logic wv; logic [31:0] wa; logic [3:0] wid; logic [63:0] wd; logic wl;
    logic gnt; logic rvld;
    logic req; logic we; logic [31:0] addr; logic [63:0] wdat; logic rrdy; logic wrdy;
    logic rspv; logic rspwe; logic [3:0] rspid; logic rspl; logic busy;
  } vec_t;

  function automatic vec_t v(
    input logic rv, input logic [31:0] ra, input logic [3:0] rid, input logic rl,
    input logic wv, input logic [31:0] wa, input logic [3:0] wid, input logic [63:0] wd, input logic wl,
    input logic gnt, input logic rvld,
    input logic req, input logic we, input logic [31:0] addr, input logic [63:0] wdat,
    input logic rrdy, input logic wrdy,
    input logic rspv, input logic rspwe, input logic [3:0] rspid, input logic rspl, input logic busy);
    v = '{rv, ra, rid, rl, wv, wa, wid, wd, wl, gnt, rvld,
          req, we, addr, wdat, rrdy, wrdy, rspv, rspwe, rspid, rspl, busy};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    rd_valid_i = x.rv; rd_addr_i = x.ra; rd_id_i = x.rid; rd_last_i = x.rl;
    wr_valid_i = x.wv; wr_addr_i = x.wa; wr_id_i = x.wid; wr_data_i = x.wd; wr_last_i = x.wl;
    mem_gnt_i = x.gnt; mem_rvalid_i = x.rvld;
  endtask

  task automatic check_vec(input string p, input vec_t x);
    chk({p, ".req"}, 64'(mem_req_o), 64'(x.req));
    chk({p, ".we"}, 64'(mem_we_o), 64'(x.we));
    chk({p, ".addr"}, 64'(mem_addr_o), 64'(x.addr));
    chk({p, ".wdata"}, mem_wdata_o, x.wdat);
    chk({p, ".strb"}, 64'(mem_strb_o), x.we ? 64'hFF : 64'h0);
    chk({p, ".rd_ready"}, 64'(rd_ready_o), 64'(x.rrdy));
    chk({p, ".wr_ready"}, 64'(wr_ready_o), 64'(x.wrdy));
    chk({p, ".rsp_valid"}, 64'(rsp_valid_o), 64'(x.rspv));
    chk({p, ".rsp_we"}, 64'(rsp_we_o), 64'(x.rspwe));
    chk({p, ".rsp_id"}, 64'(rsp_id_o), 64'(x.rspid));
    chk({p, ".rsp_last"}, 64'(rsp_last_o), 64'(x.rspl));
    chk({p, ".busy"}, 64'(busy_o), 64'(x.busy));
  endtask

  vec_t z;
  vec_t tbl [$];

  initial begin
    z = v(0,0,0,0, 0,0,0,0,0, 0,0, 0,0,0,0, 0,0, 0,0,0,0, 0);
    drive(z);
    #1;
    chk("rst.busy", 64'(busy_o), 64'h0);
    chk("rst.req", 64'(mem_req_o), 64'h0);
    chk("rst.rsp_id", 64'(rsp_id_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
`ifndef AXI_TO_MEM_RW_SCHED_WR_PRIO_EN
    // both valid 1-beat bursts: read first (reset priority), then write
    tbl.push_back(v(1,'h100,1,1, 1,'h200,2,'hAAAA,1, 1,0, 1,0,'h100,0, 1,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0, 1,'h200,2,'hAAAA,1, 1,1, 1,1,'h200,'hAAAA, 0,1, 1,0,1,1, 1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 0,1, 0,0,0,0, 0,0, 1,1,2,1, 1));
    // 4-beat read burst locks out a pending write
    tbl.push_back(v(1,'h300,3,0, 1,'h400,4,'hBBBB,1, 1,0, 1,0,'h300,0, 1,0, 0,0,0,0, 0));
    tbl.push_back(v(1,'h308,3,0, 1,'h400,4,'hBBBB,1, 1,1, 1,0,'h308,0, 1,0, 1,0,3,0, 1));
    tbl.push_back(v(1,'h310,3,0, 1,'h400,4,'hBBBB,1, 1,1, 1,0,'h310,0, 1,0, 1,0,3,0, 1));
    tbl.push_back(v(1,'h318,3,1, 1,'h400,4,'hBBBB,1, 1,1, 1,0,'h318,0, 1,0, 1,0,3,0, 1));
    tbl.push_back(v(0,0,0,0, 1,'h400,4,'hBBBB,1, 1,1, 1,1,'h400,'hBBBB, 0,1, 1,0,3,1, 1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 0,1, 0,0,0,0, 0,0, 1,1,4,1, 1));
    // write stalled by mem_gnt_i=0 for 3 cycles
    tbl.push_back(v(0,0,0,0, 1,'h500,5,'hCCCC,1, 0,0, 1,1,'h500,'hCCCC, 0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0, 1,'h500,5,'hCCCC,1, 0,0, 1,1,'h500,'hCCCC, 0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0, 1,'h500,5,'hCCCC,1, 0,0, 1,1,'h500,'hCCCC, 0,0, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0, 1,'h500,5,'hCCCC,1, 1,0, 1,1,'h500,'hCCCC, 0,1, 0,0,0,0, 0));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 0,1, 0,0,0,0, 0,0, 1,1,5,1, 1));
    // FIFO full: third read beat blocked, no same-cycle bypass on pop
    tbl.push_back(v(1,'h600,6,0, 0,0,0,0,0, 1,0, 1,0,'h600,0, 1,0, 0,0,0,0, 0));
    tbl.push_back(v(1,'h608,6,0, 0,0,0,0,0, 1,0, 1,0,'h608,0, 1,0, 0,0,6,0, 1));
    tbl.push_back(v(1,'h610,6,1, 0,0,0,0,0, 1,0, 0,0,'h610,0, 0,0, 0,0,6,0, 1));
    tbl.push_back(v(1,'h610,6,1, 0,0,0,0,0, 1,1, 0,0,'h610,0, 0,0, 1,0,6,0, 1));
    tbl.push_back(v(1,'h610,6,1, 0,0,0,0,0, 1,0, 1,0,'h610,0, 1,0, 0,0,6,0, 1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 0,1, 0,0,0,0, 0,0, 1,0,6,0, 1));
    tbl.push_back(v(0,0,0,0, 0,0,0,0,0, 0,1, 0,0,0,0, 0,0, 1,0,6,1, 1));
    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i]);
      #1;
      check_vec($sformatf("v%0d", i), tbl[i]);
    end
    // reset mid-lock with two outstanding; priority is write at this point
    @(negedge clk_i);
    drive(v(1,'h700,7,0, 0,0,0,0,0, 1,0, 0,0,0,0, 0,0, 0,0,0,0, 0));
    #1 chk("rl.beat0.rd_ready", 64'(rd_ready_o), 64'h1);
    @(negedge clk_i);
    rd_addr_i = 'h708;
    #1 chk("rl.beat1.rd_ready", 64'(rd_ready_o), 64'h1);
    @(negedge clk_i);
    drive(z);
    #1 chk("rl.pre_busy", 64'(busy_o), 64'h1);
    rst_ni = 1'b0;
    #1;
    chk("rl.busy", 64'(busy_o), 64'h0);
    chk("rl.req", 64'(mem_req_o), 64'h0);
    chk("rl.rsp_we", 64'(rsp_we_o), 64'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    drive(v(1,'h800,8,1, 1,'h900,9,'hDDDD,1, 1,0, 0,0,0,0, 0,0, 0,0,0,0, 0));
    #1;
    chk("rl.after.rd_ready", 64'(rd_ready_o), 64'h1);
    chk("rl.after.wr_ready", 64'(wr_ready_o), 64'h0);
    chk("rl.after.addr", 64'(mem_addr_o), 64'h800);
`else
    // write always wins in IDLE when both are valid
    tbl.push_back(v(1,'h100,1,1, 1,'h200,2,'hAAAA,1, 1,0, 1,1,'h200,'hAAAA, 0,1, 0,0,0,0, 0));
    tbl.push_back(v(1,'h100,1,1, 1,'h208,3,'hBBBB,1, 1,1, 1,1,'h208,'hBBBB, 0,1, 1,1,2,1, 1));
    tbl.push_back(v(1,'h100,1,1, 1,'h210,4,'hCCCC,1, 1,1, 1,1,'h210,'hCCCC, 0,1, 1,1,3,1, 1));
    tbl.push_back(v(1,'h100,1,1, 0,0,0,0,0, 1,1, 1,0,'h100,0, 1,0, 1,1,4,1, 1));
    foreach (tbl[i]) begin
      @(negedge clk_i);
      drive(tbl[i]);
      #1;
      check_vec($sformatf("wp%0d", i), tbl[i]);
    end
`endif
    @(negedge clk_i);
    drive(z);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/axi_to_mem_rw_sched.md
Name: axi_to_mem_rw_sched

Overview:
Beat-level scheduler for the memory port behind the burst splitters. It takes single-beat read requests (split AR stream) and single-beat write requests (split AW joined with W) and shares one memory request port between them. It holds the grant for a whole original burst and alternates round-robin between bursts. It tracks outstanding memory accesses in order, so each response can be routed back with its ID, direction and last flag.

Parameters:
AddrWidth, 32, memory address width
DataWidth, 64, memory data width
IdWidth, 4, AXI ID width carried in metadata
MaxOutstanding, 2, depth of the in-order response-metadata FIFO (>=1)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rd_valid_i  in  1  read beat request valid
rd_ready_o  out  1  read beat accepted
rd_addr_i  in  AddrWidth  read beat address
rd_id_i  in  IdWidth  AXI ID
rd_last_i  in  1  final beat of split burst
wr_valid_i  in  1  write beat request valid
wr_ready_o  out  1  write beat accepted
wr_addr_i  in  AddrWidth  write beat address
wr_id_i  in  IdWidth  AXI ID
wr_data_i  in  DataWidth  write data
wr_strb_i  in  DataWidth/8  byte strobes
wr_last_i  in  1  final beat of split burst
mem_req_o  out  1  memory request
mem_gnt_i  in  1  memory grant
mem_addr_o  out  AddrWidth  memory address
mem_we_o  out  1  1=write
mem_wdata_o  out  DataWidth  write data (0 on reads)
mem_strb_o  out  DataWidth/8  strobes (0 on reads)
mem_rvalid_i  in  1  in-order memory response valid
rsp_valid_o  out  1  response metadata valid (=mem_rvalid_i)
rsp_we_o  out  1  response belongs to write
rsp_id_o  out  IdWidth  ID of response
rsp_last_o  out  1  response is last beat of its burst
busy_o  out  1  lock held or FIFO non-empty

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_ni is asynchronous, active-low. On reset: state=IDLE, prio_q=read, FIFO empty, count=0. All outputs are combinational and read 0 while their sources are idle.
- States:
  - IDLE: select a requester. If only one is valid, select it. If both are valid, select the one indicated by prio_q.
  - LOCK_RD / LOCK_WR: only the locked side may be selected. The other side's ready stays 0 regardless of its valid.
- Request and handshake:
  - mem_req_o = selected_valid && (count != MaxOutstanding).
  - The address, we, data and strb of the selected side drive the mem_* outputs combinationally.
  - Handshake = mem_req_o && mem_gnt_i. The selected side's ready equals the handshake in the same cycle (zero latency, no request register).
  - Requests must hold stable while valid and not ready.
- State transitions on handshake:
  - last=0: next state = LOCK_<side>.
  - last=1: next state = IDLE, and prio_q flips to the other side.
- No handshake: state and prio_q are unchanged. A lock persists indefinitely while the locked side is idle.
- Metadata FIFO:
  - Push {we,id,last} on handshake.
  - Pop on mem_rvalid_i. rsp_we_o, rsp_id_o and rsp_last_o show the head.
  - Push and pop in the same cycle leave count unchanged.
  - When full, mem_req_o is held low even if a pop occurs that cycle (no bypass).
  - mem_rvalid_i while empty is a protocol violation: assertion fires, state is unchanged.
- Widths: count is $clog2(MaxOutstanding+1) bits. Pointers wrap modulo MaxOutstanding.
- Reset mid-operation: the lock and all outstanding metadata are discarded. Responses arriving after reset are protocol violations.

Optional Feature:
AXI_TO_MEM_RW_SCHED_WR_PRIO_EN
- Defined: in IDLE with both sides valid, write always wins and prio_q is unused. Burst locking is unchanged.
- Undefined: round-robin as above.

Decomposition:
- Package axi_to_mem_pkg holds:
  - sched_state_e {IDLE, LOCK_RD, LOCK_WR}
  - typedef rsp_meta_t {we, id, last}
- Sub-module axi_to_mem_meta_fifo: a generic in-order FIFO of rsp_meta_t with push/pop/full/empty/head. It is the only natural split.

Test Plan:
1. Both valid from reset, each a 1-beat burst, mem_gnt_i=1 -> read granted in cycle 0, write in cycle 1; rsp order we=0 then we=1.
2. 4-beat read burst plus write valid throughout -> wr_ready_o=0 for all 4 read beats; the write is granted on the cycle after rd_last_i.
3. MaxOutstanding=2, mem_rvalid_i held 0, 3 read beats -> 2 accepted, mem_req_o=0 on the 3rd. Pulsing mem_rvalid_i once -> 3rd accepted the next cycle, not the same cycle.
4. mem_gnt_i=0 for 3 cycles with a write pending -> mem_req_o=1 stable with unchanged addr/data, wr_ready_o=0, no FIFO push.
5. Assert rst_ni mid-lock with 2 outstanding -> busy_o=0 and state IDLE immediately; the next request starts from read priority.
6. With AXI_TO_MEM_RW_SCHED_WR_PRIO_EN, alternating 1-beat bursts with both sides valid -> write always wins in IDLE.
